reg_bus_rr_arbiter: RTL and testbench

// - Shares one internal register access port (addr/w_vld/r_vld/byte_enable/sw_wr_bus) between N_REQ bus widgets.
// - Typical sources: several AHB-Lite widgets, or a widget plus a debug master.
// - Round-robin grant; sequences one access at a time: issue strobe, wait for register response, return it.
// - Sits between the bus widgets and the generated register block.

---
 rtl/reg_bus_rr_arbiter_if.sv | 49 ++++
 rtl/reg_bus_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_reg_bus_rr_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_rr_arbiter_if.sv
// reg_bus_rr_arbiter_if: groups the requester side and the register-block side of the
//    register access arbiter into one bundle.
// Ports (signals):
//    requester side  : req_vld, req_write, req_addr, req_be, req_wdata -> arbiter
//                      req_ack, req_rdata, req_err                     <- arbiter
//    register side   : addr, w_vld, r_vld, byte_enable, sw_wr_bus     <- arbiter
//                      rsp_vld, rsp_rdata, rsp_err                     -> arbiter
// Modports: slave = arbiter view, master = view of the widgets plus register block.
interface reg_bus_rr_arbiter_if #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   // requester side, requester i occupies slice i of each packed vector
   logic [N_REQ-1:0]        req_vld;
   logic [N_REQ-1:0]        req_write;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*BE_W-1:0]   req_be;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        req_ack;
   logic [DATA_W-1:0]       req_rdata;
   logic                    req_err;

   // register block side
   logic [ADDR_W-1:0]       addr;
   logic                    w_vld;
   logic                    r_vld;
   logic [BE_W-1:0]         byte_enable;
   logic [DATA_W-1:0]       sw_wr_bus;
   logic                    rsp_vld;
   logic [DATA_W-1:0]       rsp_rdata;
   logic                    rsp_err;

   modport slave (
      input  req_vld, req_write, req_addr, req_be, req_wdata,
      output req_ack, req_rdata, req_err,
      output addr, w_vld, r_vld, byte_enable, sw_wr_bus,
      input  rsp_vld, rsp_rdata, rsp_err
   );

   modport master (
      output req_vld, req_write, req_addr, req_be, req_wdata,
      input  req_ack, req_rdata, req_err,
      input  addr, w_vld, r_vld, byte_enable, sw_wr_bus,
      output rsp_vld, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/reg_bus_rr_arbiter.sv
// reg_bus_rr_arbiter: round-robin share of one register access port between N_REQ widgets.
// Latency: req_vld at T -> w_vld/r_vld at T+1 -> req_ack one cycle after rsp_vld (T+2 minimum).
// Backpressure: one access in flight; losing requesters hold req_vld until their req_ack.
// Ports: HCLK, HRESETn (async active-low) plus bus (reg_bus_rr_arbiter_if.slave) carrying the
//    requester handshake (req_*) and the register block port (addr/w_vld/r_vld/byte_enable/
//    sw_wr_bus out, rsp_vld/rsp_rdata/rsp_err in).
// Optional build macro REG_ARB_TIMEOUT_EN: abort an access with req_err=1 when no rsp_vld
//    arrives within TIMEOUT_CYC cycles of the strobe; without it WAIT is held indefinitely.
module reg_bus_rr_arbiter #(
   parameter int N_REQ       = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   reg_bus_rr_arbiter_if.slave  bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW    = IDX_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;     // last granted requester
   logic [IDX_W-1:0] win_idx;    // requester owning the access in flight
   logic             win_write;  // registered direction of the access in flight

   // ------------------------------------------------------------------
   // Round-robin pick: first requesting index after rr_ptr, wrapping.
   // cand is one bit wider so rr_ptr+k never overflows before the wrap.
   // ------------------------------------------------------------------
   logic             any_req;
   logic [IDX_W-1:0] pick;
   logic [CW-1:0]    cand;

   always_comb begin
      any_req = 1'b0;
      pick    = '0;
      cand    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, rr_ptr} + CW'(k);
         if (cand >= CW'(N_REQ)) begin
            cand = cand - CW'(N_REQ);
         end
         if (!any_req && bus.req_vld[cand[IDX_W-1:0]]) begin
            any_req = 1'b1;
            pick    = cand[IDX_W-1:0];
         end
      end
   end

   // one-hot ack for the requester in flight
   logic [N_REQ-1:0] win_onehot;

   always_comb begin
      win_onehot          = '0;
      win_onehot[win_idx] = 1'b1;
   end

`ifdef REG_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   // Counts cycles since the strobe; loaded with 1 on the strobe cycle so that
   // reaching TIMEOUT_CYC in ISSUE/WAIT lands DONE exactly TIMEOUT_CYC after it.
   logic [TO_W-1:0] to_cnt;
   logic            to_hit;

   assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC));
`endif

   // ------------------------------------------------------------------
   // Access sequencer. Every output is a register; strobes, ack and the
   // returned data default low each cycle so they are single-cycle pulses.
   // ------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state           <= IDLE;
         rr_ptr          <= IDX_W'(N_REQ - 1);
         win_idx         <= '0;
         win_write       <= 1'b0;
         bus.addr        <= '0;
         bus.byte_enable <= '0;
         bus.sw_wr_bus   <= '0;
         bus.w_vld       <= 1'b0;
         bus.r_vld       <= 1'b0;
         bus.req_ack     <= '0;
         bus.req_rdata   <= '0;
         bus.req_err     <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
         to_cnt          <= '0;
`endif
      end else begin
         bus.w_vld     <= 1'b0;
         bus.r_vld     <= 1'b0;
         bus.req_ack   <= '0;
         bus.req_rdata <= '0;
         bus.req_err   <= 1'b0;

         case (state)
            IDLE: begin
               if (any_req) begin
                  // snapshot the winner; later changes on its req_* are ignored
                  state           <= ISSUE;
                  rr_ptr          <= pick;
                  win_idx         <= pick;
                  win_write       <= bus.req_write[pick];
                  bus.addr        <= bus.req_addr[pick*ADDR_W +: ADDR_W];
                  bus.byte_enable <= bus.req_be[pick*BE_W +: BE_W];
                  bus.sw_wr_bus   <= bus.req_wdata[pick*DATA_W +: DATA_W];
                  bus.w_vld       <= bus.req_write[pick];
                  bus.r_vld       <= !bus.req_write[pick];
`ifdef REG_ARB_TIMEOUT_EN
                  to_cnt          <= TO_W'(1);
`endif
               end
            end

            ISSUE, WAIT: begin
               // a response in the strobe cycle itself is accepted here too
               if (bus.rsp_vld) begin
                  state         <= DONE;
                  bus.req_ack   <= win_onehot;
                  bus.req_rdata <= win_write ? '0 : bus.rsp_rdata;
                  bus.req_err   <= bus.rsp_err;
               end
`ifdef REG_ARB_TIMEOUT_EN
               else if (to_hit) begin
                  state         <= DONE;
                  bus.req_ack   <= win_onehot;
                  bus.req_rdata <= '0;
                  bus.req_err   <= 1'b1;
               end else begin
                  state  <= WAIT;
                  to_cnt <= to_cnt + TO_W'(1);
               end
`else
               else begin
                  state <= WAIT;
               end
`endif
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bus_rr_arbiter.sv
// tb_reg_bus_rr_arbiter: random requesters and a random-latency register block against a
//    cycle-scheduled reference of the arbiter (grant order, strobe/ack timing, returned data).
// Ports: none; clock and reset generated here, DUT bus carried by reg_bus_rr_arbiter_if.
// Includes reset with both requests held, one reset in the middle of a WAIT, spurious
//    rsp_vld outside an access and field changes by a requester after its grant.
module tb_reg_bus_rr_arbiter;
   localparam int N_REQ       = 2;
   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 32;
   localparam int BE_W        = DATA_W / 8;
   localparam int TIMEOUT_CYC = 4;
   localparam int N_CYC       = 4000;
`ifdef REG_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic HCLK    = 1'b0;
   logic HRESETn = 1'b1;

   always #5 HCLK = ~HCLK;

   reg_bus_rr_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   reg_bus_rr_arbiter #(
      .N_REQ      (N_REQ),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .HCLK   (HCLK),
      .HRESETn(HRESETn),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // requester state: an outstanding request and its fields
   bit              pend   [N_REQ];
   bit              p_wr   [N_REQ];
   logic [ADDR_W-1:0] p_addr [N_REQ];
   logic [BE_W-1:0]   p_be   [N_REQ];
   logic [DATA_W-1:0] p_wd   [N_REQ];

   // reference schedule for the access in flight
   bit              busy;
   int              last_win;
   int              g_win;
   bit              g_wr;
   logic [ADDR_W-1:0] g_addr;
   logic [BE_W-1:0]   g_be;
   logic [DATA_W-1:0] g_wd;
   logic [DATA_W-1:0] g_rdata;
   bit              g_err;
   int              t_strobe, t_rsp, t_ack, late_cyc, next_arb;
   logic [DATA_W-1:0] rsp_dat;
   bit              rsp_e;

   // value expected on the register-side address/data outputs
   logic [ADDR_W-1:0] sh_addr;
   logic [BE_W-1:0]   sh_be;
   logic [DATA_W-1:0] sh_wd;

   int rst_left;
   bit mid_rst_done;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all_zero();
      chk("rst_req_ack",   64'(bus.req_ack),     64'd0);
      chk("rst_req_rdata", 64'(bus.req_rdata),   64'd0);
      chk("rst_req_err",   64'(bus.req_err),     64'd0);
      chk("rst_w_vld",     64'(bus.w_vld),       64'd0);
      chk("rst_r_vld",     64'(bus.r_vld),       64'd0);
      chk("rst_addr",      64'(bus.addr),        64'd0);
      chk("rst_be",        64'(bus.byte_enable), 64'd0);
      chk("rst_wdata",     64'(bus.sw_wr_bus),   64'd0);
   endtask

   task automatic new_req(input int i);
      pend[i]   = 1'b1;
      p_wr[i]   = 1'($urandom_range(0, 1));
      p_addr[i] = ADDR_W'($urandom);
      p_be[i]   = BE_W'($urandom);
      p_wd[i]   = DATA_W'($urandom);
   endtask

   // Drive requester and register-block inputs for cycle c.
   task automatic drive(input int c);
      bit rsp_now;
      bit spur_ok;
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_vld[i] = pend[i];
         if (busy && i == g_win && c >= t_strobe && $urandom_range(0, 2) == 0) begin
            bus.req_write[i]                   = ~p_wr[i];
            bus.req_addr[i*ADDR_W +: ADDR_W]   = ADDR_W'($urandom);
            bus.req_be[i*BE_W +: BE_W]         = BE_W'($urandom);
            bus.req_wdata[i*DATA_W +: DATA_W]  = DATA_W'($urandom);
         end else begin
            bus.req_write[i]                   = p_wr[i];
            bus.req_addr[i*ADDR_W +: ADDR_W]   = p_addr[i];
            bus.req_be[i*BE_W +: BE_W]         = p_be[i];
            bus.req_wdata[i*DATA_W +: DATA_W]  = p_wd[i];
         end
      end
      rsp_now = (busy && c == t_rsp) || (c == late_cyc);
      spur_ok = !busy || c < t_strobe || c >= t_ack;
      if (rsp_now) begin
         bus.rsp_vld   = 1'b1;
         bus.rsp_rdata = rsp_dat;
         bus.rsp_err   = rsp_e;
      end else begin
         bus.rsp_vld   = spur_ok && ($urandom_range(0, 3) == 0);
         bus.rsp_rdata = DATA_W'($urandom);
         bus.rsp_err   = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      int               acked;
      int               d;
      int               w;
      logic [N_REQ-1:0] exp_ack;
      bit               at_strobe;
      bit               at_ack;

      busy = 1'b0; last_win = N_REQ - 1; g_win = 0; g_wr = 1'b0;
      g_addr = '0; g_be = '0; g_wd = '0; g_rdata = '0; g_err = 1'b0;
      t_strobe = -1; t_rsp = -1; t_ack = -1; late_cyc = -1; next_arb = 0;
      rsp_dat = '0; rsp_e = 1'b0;
      sh_addr = '0; sh_be = '0; sh_wd = '0;
      mid_rst_done = 1'b0;

      // both requesters pending and held through reset
      for (int i = 0; i < N_REQ; i++) new_req(i);
      drive(-1);
      #1 HRESETn = 1'b0;
      rst_left = 3;

      for (int c = 0; c < N_CYC; c++) begin
         @(negedge HCLK);

         if (rst_left > 0) begin
            chk_all_zero();
            rst_left--;
            if (rst_left > 0) begin
               drive(c);
               continue;
            end
            HRESETn  = 1'b1;
            next_arb = c;
         end

         // reset while an access sits in WAIT: aborted, never acked
         if (!mid_rst_done && c > N_CYC / 2 && busy && c > t_strobe && c < t_ack) begin
            mid_rst_done = 1'b1;
            HRESETn      = 1'b0;
            #1;
            chk_all_zero();
            busy     = 1'b0;
            last_win = N_REQ - 1;
            late_cyc = -1;
            sh_addr  = '0;
            sh_be    = '0;
            sh_wd    = '0;
            rst_left = 2;
            drive(c);
            continue;
         end

         at_strobe = busy && c == t_strobe;
         at_ack    = busy && c == t_ack;
         if (at_strobe) begin
            sh_addr = g_addr;
            sh_be   = g_be;
            sh_wd   = g_wd;
         end
         exp_ack = '0;
         if (at_ack) exp_ack[g_win] = 1'b1;

         chk("w_vld",       64'(bus.w_vld),       64'(at_strobe && g_wr));
         chk("r_vld",       64'(bus.r_vld),       64'(at_strobe && !g_wr));
         chk("req_ack",     64'(bus.req_ack),     64'(exp_ack));
         chk("req_rdata",   64'(bus.req_rdata),   at_ack ? 64'(g_rdata) : 64'd0);
         chk("req_err",     64'(bus.req_err),     at_ack ? 64'(g_err) : 64'd0);
         chk("addr",        64'(bus.addr),        64'(sh_addr));
         chk("byte_enable", 64'(bus.byte_enable), 64'(sh_be));
         chk("sw_wr_bus",   64'(bus.sw_wr_bus),   64'(sh_wd));

         // requester drops req_vld in its ack cycle
         acked = -1;
         if (at_ack) begin
            pend[g_win] = 1'b0;
            busy        = 1'b0;
            acked       = g_win;
         end

         for (int i = 0; i < N_REQ; i++) begin
            if (!pend[i] && i != acked && $urandom_range(0, 3) == 0) new_req(i);
         end

         // arbitration cycle: grant first pending index after the last winner
         if (!busy && c >= next_arb) begin
            w = -1;
            for (int k = 1; k <= N_REQ; k++) begin
               if (w < 0 && pend[(last_win + k) % N_REQ]) w = (last_win + k) % N_REQ;
            end
            if (w >= 0) begin
               busy     = 1'b1;
               last_win = w;
               g_win    = w;
               g_wr     = p_wr[w];
               g_addr   = p_addr[w];
               g_be     = p_be[w];
               g_wd     = p_wd[w];
               rsp_dat  = DATA_W'($urandom);
               rsp_e    = 1'($urandom_range(0, 1));
               d        = TO_EN ? int'($urandom_range(0, TIMEOUT_CYC + 1)) : int'($urandom_range(0, 3));
               t_strobe = c + 1;
               if (TO_EN && d >= TIMEOUT_CYC) begin
                  t_ack    = t_strobe + TIMEOUT_CYC;
                  t_rsp    = -1;
                  late_cyc = t_strobe + d;
                  g_rdata  = '0;
                  g_err    = 1'b1;
               end else begin
                  t_rsp    = t_strobe + d;
                  t_ack    = t_strobe + d + 1;
                  g_rdata  = g_wr ? '0 : rsp_dat;
                  g_err    = rsp_e;
               end
               next_arb = t_ack + 1;
            end
         end

         drive(c);
      end

      if (!mid_rst_done) chk("mid_reset_reached", 64'd0, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
